arp_req_arb: RTL

- Round-robin arbiter that shares the single ARP request/response channel of the ARP block between PORTS independent requesters, e.g. UDP TX path, ICMP responder and host config path.
- Sits between the requesters and the ARP block's arp_request_*/arp_response_* interface.
- Keeps one lookup outstanding at a time and routes each response back to the requester that issued it.

---
 rtl/arp_req_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arp_req_arb.sv
// Round-robin arbiter sharing one ARP request/response channel between
// PORTS requesters. Only one lookup is in flight at a time. The response
// is steered back to the port that issued the request.
module arp_req_arb #(
   parameter int PORTS    = 4,
   parameter int CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [PORTS-1:0]      s_arp_request_valid,
   output logic [PORTS-1:0]      s_arp_request_ready,
   input  logic [PORTS*32-1:0]   s_arp_request_ip,

   output logic [PORTS-1:0]      s_arp_response_valid,
   input  logic [PORTS-1:0]      s_arp_response_ready,
   output logic [PORTS-1:0]      s_arp_response_error,
   output logic [PORTS*48-1:0]   s_arp_response_mac,

   output logic                  m_arp_request_valid,
   input  logic                  m_arp_request_ready,
   output logic [31:0]           m_arp_request_ip,

   input  logic                  m_arp_response_valid,
   output logic                  m_arp_response_ready,
   input  logic                  m_arp_response_error,
   input  logic [47:0]           m_arp_response_mac,

   output logic                  busy,
   output logic [CL_PORTS-1:0]   grant_index
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_reg;
   logic [CL_PORTS-1:0] grant_reg;
   logic [CL_PORTS-1:0] last_grant_reg;
   logic [31:0]         ip_reg;
   logic                m_req_valid_reg;

   logic [CL_PORTS-1:0] sel;
   logic                any_valid;
   logic [31:0]         sel_ip;
   logic [PORTS-1:0]    resp_ready_term;

   // Round-robin pick: the first requesting port after last_grant, wrapping.
   // Offsets are scanned from farthest to nearest so the nearest match wins.
   always_comb begin
      sel       = '0;
      any_valid = |s_arp_request_valid;
      for (int k = PORTS; k >= 1; k--) begin
         for (int i = 0; i < PORTS; i++) begin
            if (s_arp_request_valid[i] && (i == (int'(last_grant_reg) + k) % PORTS)) begin
               sel = CL_PORTS'(i);
            end
         end
      end
   end

   // IP of the selected requester, captured on accept.
   always_comb begin
      sel_ip = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (sel == CL_PORTS'(i)) begin
            sel_ip = s_arp_request_ip[32*i +: 32];
         end
      end
   end

   // Per-port request accept and response steering.
   genvar gi;
   generate
      for (gi = 0; gi < PORTS; gi++) begin : g_port
         // Gated by rst so every accept drops the moment reset is applied.
         assign s_arp_request_ready[gi]  = !rst && (state_reg == IDLE) && any_valid &&
                                           (sel == CL_PORTS'(gi));
         assign s_arp_response_valid[gi] = (state_reg == RESP) && (grant_reg == CL_PORTS'(gi)) &&
                                           m_arp_response_valid;
         assign s_arp_response_error[gi] = m_arp_response_error;
         assign s_arp_response_mac[48*gi +: 48] = m_arp_response_mac;
         assign resp_ready_term[gi]      = (grant_reg == CL_PORTS'(gi)) && s_arp_response_ready[gi];
      end
   endgenerate

   // Outside RESP the ARP block's response is stalled, never consumed.
   assign m_arp_response_ready = (state_reg == RESP) && (|resp_ready_term);
   assign m_arp_request_valid  = m_req_valid_reg;
   assign m_arp_request_ip     = ip_reg;
   assign busy                 = (state_reg != IDLE);
   assign grant_index          = grant_reg;

   // Transaction sequencer: accept, forward the request, wait for the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         last_grant_reg  <= CL_PORTS'(PORTS - 1);
         ip_reg          <= '0;
         m_req_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_valid) begin
                  grant_reg       <= sel;
                  ip_reg          <= sel_ip;
                  m_req_valid_reg <= 1'b1;
                  state_reg       <= REQ;
               end
            end
            REQ: begin
               if (m_arp_request_ready) begin
                  m_req_valid_reg <= 1'b0;
                  state_reg       <= RESP;
               end
            end
            RESP: begin
               if (m_arp_response_valid && m_arp_response_ready) begin
                  last_grant_reg <= grant_reg;
                  state_reg      <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
